// File: rtl/math_add_arb_pkg.sv
// Shared math arbitration helpers: requester-tag width and cyclic-priority pick.
package math_pkg;

  localparam int unsigned RR_MAX   = 16;
  localparam int unsigned RR_IDX_W = 4;
  localparam int unsigned RR_CNT_W = RR_IDX_W + 1;

  typedef struct packed {
    logic                hit;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid[0..n-1], searching upward from ptr and wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int unsigned n);
    rr_pick_t r;
    logic [RR_CNT_W-1:0] i;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      i = {1'b0, ptr} + RR_CNT_W'(k);
      if (i >= RR_CNT_W'(n)) i = i - RR_CNT_W'(n);
      if (k < n && !r.hit && valid[i[RR_IDX_W-1:0]]) begin
        r.hit = 1'b1;
        r.idx = i[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/math_add_arb_if.sv
// Requester and result handshake bundle of the shared-adder arbiter.
interface math_add_arb_if
  import math_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ID_WIDTH = id_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_dina;
  logic [NUM_REQ*WIDTH-1:0] req_dinb;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_sum;
  logic [ID_WIDTH-1:0]      res_id;
  logic                     res_ovf;
  logic                     busy;

  modport slave (
    input  req_valid, req_dina, req_dinb, res_ready,
    output req_ready, res_valid, res_sum, res_id, res_ovf, busy
  );

  modport master (
    output req_valid, req_dina, req_dinb, res_ready,
    input  req_ready, res_valid, res_sum, res_id, res_ovf, busy
  );
endinterface

// File: rtl/math_add_arb_rr_arb.sv
// Round-robin grant with a rotating priority pointer that only moves on a grant.
module rr_arb
  import math_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 4,
  localparam int unsigned ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  grant,
  output logic                grant_vld,
  output logic [ID_WIDTH-1:0] grant_id
);
  logic [ID_WIDTH-1:0] ptr;
  rr_pick_t            pick;

  always_comb begin
    pick      = rr_pick(RR_MAX'(req_valid), RR_IDX_W'(ptr), NUM_REQ);
    grant_vld = rst_n & ena & pick.hit;
    grant_id  = ID_WIDTH'(pick.idx);
    grant     = grant_vld ? (NUM_REQ'(1) << pick.idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (pick.idx == RR_IDX_W'(NUM_REQ - 1)) ? '0 : ID_WIDTH'(pick.idx + 1'b1);
    end
  end
endmodule

// File: rtl/math_add_fab.sv
// Pipelined wrapping adder; dout follows its operands by LATENCY enabled edges.
module math_add_fab #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] dina,
  input  logic [WIDTH-1:0] dinb,
  output logic [WIDTH-1:0] dout
);
  if (LATENCY == 0) begin : g_comb
    assign dout = dina + dinb;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe [LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned s = 0; s < LATENCY; s++) pipe[s] <= '0;
      end else if (ena) begin
        pipe[0] <= dina + dinb;
        for (int unsigned s = 1; s < LATENCY; s++) pipe[s] <= pipe[s-1];
      end
    end

    assign dout = pipe[LATENCY-1];
  end
endmodule

// File: rtl/shift_reg.sv
// Enabled shift register; occupied reports any stage holding a set MSB (valid bit).
module shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             occupied
);
  if (DEPTH == 0) begin : g_pass
    assign q        = d;
    assign occupied = 1'b0;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned s = 0; s < DEPTH; s++) stage[s] <= '0;
      end else if (ena) begin
        stage[0] <= d;
        for (int unsigned s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
      end
    end

    always_comb begin
      occupied = 1'b0;
      for (int unsigned s = 0; s < DEPTH; s++) occupied = occupied | stage[s][WIDTH-1];
    end

    assign q = stage[DEPTH-1];
  end
endmodule

// File: rtl/math_add_arb.sv
// Shares one pipelined adder among NUM_REQ requesters; tags ride alongside the sum.
module math_add_arb
  import math_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 1
) (
  input logic            clk,
  input logic            rst_n,
  math_add_arb_if.slave  bus
);
  localparam int unsigned ID_WIDTH = id_width(NUM_REQ);
  localparam int unsigned TAG_W    = ID_WIDTH + 3;

  logic                rst, ena, grant_vld, tag_busy;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic [WIDTH-1:0]    dina, dinb, dout;
  logic [TAG_W-1:0]    tag_in, tag_out;
  logic                res_valid, res_ovf;
  logic [WIDTH-1:0]    res_sum;
  logic [ID_WIDTH-1:0] res_id;

  assign rst = ~rst_n;
  // A held result stalls everything upstream, including the arbiter.
  assign ena = ~res_valid | bus.res_ready;

  rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .req_valid(bus.req_valid),
    .grant    (grant),
    .grant_vld(grant_vld),
    .grant_id (grant_id)
  );

  always_comb begin
    dina = '0;
    dinb = '0;
    if (grant_vld) begin
      dina = bus.req_dina[grant_id*WIDTH +: WIDTH];
      dinb = bus.req_dinb[grant_id*WIDTH +: WIDTH];
    end
    tag_in = {grant_vld, grant_id, dina[WIDTH-1], dinb[WIDTH-1]};
  end

  shift_reg #(.WIDTH(TAG_W), .DEPTH(LATENCY)) u_tag (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .d       (tag_in),
    .q       (tag_out),
    .occupied(tag_busy)
  );

  math_add_fab #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_add (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .dina(dina),
    .dinb(dinb),
    .dout(dout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      res_ovf   <= 1'b0;
    end else if (ena) begin
      res_valid <= tag_out[TAG_W-1];
      if (tag_out[TAG_W-1]) begin
        res_sum <= dout;
        res_id  <= tag_out[TAG_W-2:2];
        res_ovf <= (tag_out[1] == tag_out[0]) & (dout[WIDTH-1] != tag_out[1]);
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.res_valid = res_valid;
  assign bus.res_sum   = res_sum;
  assign bus.res_id    = res_id;
  assign bus.res_ovf   = res_ovf;
  assign bus.busy      = res_valid | tag_busy;
endmodule

// File: doc/math_add_arb.md
Name: math_add_arb

Overview:
Round-robin arbiter and sequencer sharing one pipelined signed fabric adder (math_add_fab) between NUM_REQ requesters. Grants at most one operand pair per cycle, tracks each in-flight operation with a requester-ID tag pipeline matched to the adder latency, and returns sums on a single registered result port with backpressure. Sits between multiple channel accumulators and the shared adder in the Q10 math utilities.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 16, operand/sum width; must be a multiple of LATENCY+1 (adder constraint)
LATENCY, 1, adder internal latency passed to math_add_fab
ID_WIDTH, $clog2(NUM_REQ), localparam, width of requester tag

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_dina  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_dinb  in  NUM_REQ*WIDTH  operand B, same packing
res_valid  out  1  result valid
res_ready  in  1  downstream accept
res_sum  out  WIDTH  signed sum, wraps modulo 2^WIDTH
res_id  out  ID_WIDTH  index of requester that issued the operation
res_ovf  out  1  signed overflow flag for res_sum
busy  out  1  any operation in flight or result held

Behaviour:
- Clock/reset: one clock clk; reset rst_n synchronous, active-low. The adder receives rst = ~rst_n.
- Reset values: res_valid=0, res_sum=0, res_id=0, res_ovf=0, busy=0, rr pointer=0, all tag-valid bits=0. req_ready=0 while rst_n=0.
- Pipeline enable: ena = ~res_valid | res_ready. All state (pointer, tag pipeline, adder, output register) advances only when ena=1.
- Arbitration: when ena=1, grant the lowest index i, searching cyclically from ptr (i=ptr, ptr+1, ..., wrapping at NUM_REQ), with req_valid[i]=1. req_ready[i]=1 only for the granted index. When ena=0 or no valid request, req_ready=0.
- Pointer: on a grant to i, ptr <= (i+1) mod NUM_REQ. No grant leaves ptr unchanged.
- Issue: the granted operands are muxed combinationally onto adder dina/dinb in the grant cycle. With no grant, zeros are driven and the issued tag is invalid.
- Tag pipeline: a LATENCY-deep shift register of {valid, id, signA, signB} advances on ena. Depth 0 when LATENCY=0.
- Output register: on ena, res_valid <= tag_valid at pipe end; if that tag is valid, res_sum <= adder dout, res_id <= tag id, and res_ovf <= (signA==signB) & (sum MSB != signA). Otherwise res_sum, res_id and res_ovf hold their previous values.
- Latency: grant at enabled edge k gives res_valid after enabled edge k+LATENCY+1. Throughput is one operation per cycle with res_ready held high.
- Backpressure: with res_valid=1 and res_ready=0, the whole pipeline freezes. res_* stay stable, no grants occur, and no in-flight operation is lost or duplicated.
- busy = res_valid | OR of all tag valid bits.
- Reset mid-operation: all in-flight operations are discarded without producing results. ptr returns to 0.
- Requester rule: a requester may drop req_valid without a grant; the arbiter does not require valid to be held.

Decomposition:
- Shared package math_pkg holds clog2-based ID width helper and the rr-search function (cyclic priority pick), reusable by other math arbiters.
- One natural sub-module: rr_arb (NUM_REQ-wide cyclic-priority grant with pointer update, ena input).
- math_add_fab is instantiated as the datapath. The tag pipeline reuses shift_reg with WIDTH = ID_WIDTH+3 and DEPTH = LATENCY.

Test Plan:
- Single request: NUM_REQ=4, LATENCY=1, req_valid=0b0100, dina=100, dinb=-30, res_ready=1. Required: req_ready=0b0100 same cycle; two cycles later res_valid=1, res_sum=70, res_id=2, res_ovf=0.
- Round-robin fairness: all four req_valid held high for 8 cycles, res_ready=1. Required: grants in order 0,1,2,3,0,1,2,3; results emerge in the same id order, one per cycle.
- Backpressure: stream from 0b0011, res_ready=0 for 3 cycles mid-stream. Required: req_ready=0 and res_* stable during the stall; after release, no loss or duplication, and ids keep alternating 0,1.
- Overflow: WIDTH=16, dina=0x7FFF, dinb=0x0001. Required: res_sum=0x8000, res_ovf=1. Also dina=0x8000, dinb=0xFFFF: res_sum=0x7FFF, res_ovf=1.
- Reset mid-flight: LATENCY=3, issue 3 ops, then rst_n=0 for one cycle. Required: res_valid stays 0, busy=0 after reset, ptr=0 (next grant with all valid goes to 0).
- Wrap and skip: ptr=3, req_valid=0b0010. Required: grant 1, ptr becomes 2; then req_valid=0b1001 gives grant 3, ptr wraps to 0.
